// File: rtl/iob_vexriscv_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : iob_vexriscv_bus_arbiter_if
//  Description : IOb native bus bundle (request + response) with master and
//                slave views. The master drives the request; the slave
//                returns ready and the read response.
//  Revision    : 1.0 - initial release
// ============================================================================
interface iob_vexriscv_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                avalid;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                ready;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;

    // Request originator (CPU side, or the arbiter towards memory)
    modport master (
        output avalid, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    // Request consumer (memory side, or the arbiter towards the CPU)
    modport slave (
        input  avalid, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/iob_vexriscv_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : iob_vexriscv_bus_arbiter
//  Description : Two-to-one round-robin arbiter sharing a single IOb memory
//                port between the VexRiscv instruction bus (m0) and data
//                bus (m1). At most one read is outstanding; its response is
//                steered back to the requester that issued it. Writes finish
//                on the accept cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_vexriscv_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 cke_i,
    iob_vexriscv_bus_arbiter_if.slave  m0,
    iob_vexriscv_bus_arbiter_if.slave  m1,
    iob_vexriscv_bus_arbiter_if.master s,
    output logic                      busy_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;   // requester holding the port (0=m0, 1=m1)
    logic   last_q,  last_d;    // requester granted most recently
    logic   busy_q,  busy_d;

    logic              w_grant_vld;
    logic              w_grant_idx;
    logic              w_sel_avalid;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [STRB_W-1:0] w_sel_wstrb;
    logic              w_accept;
    logic              w_rd_return;

    // Grant selection: round-robin in IDLE, locked to the owner in ISSUE,
    // nobody while a read response is pending.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0.avalid && m1.avalid) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = ~last_q;
                end else if (m0.avalid) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = 1'b0;
                end else if (m1.avalid) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_grant_vld = 1'b1;
                w_grant_idx = owner_q;
            end
            default: begin
                w_grant_vld = 1'b0;
                w_grant_idx = 1'b0;
            end
        endcase
    end

    // Request mux: pick the granted requester's fields
    always_comb begin
        w_sel_avalid = m0.avalid;
        w_sel_addr   = m0.addr;
        w_sel_wdata  = m0.wdata;
        w_sel_wstrb  = m0.wstrb;
        if (w_grant_idx) begin
            w_sel_avalid = m1.avalid;
            w_sel_addr   = m1.addr;
            w_sel_wdata  = m1.wdata;
            w_sel_wstrb  = m1.wstrb;
        end
    end

    // Zero-latency forwarding; data lines are zeroed when nobody holds a grant
    assign s.avalid = w_grant_vld & w_sel_avalid;
    assign s.addr   = w_grant_vld ? w_sel_addr  : '0;
    assign s.wdata  = w_grant_vld ? w_sel_wdata : '0;
    assign s.wstrb  = w_grant_vld ? w_sel_wstrb : '0;

    assign m0.ready = w_grant_vld & ~w_grant_idx & s.ready;
    assign m1.ready = w_grant_vld &  w_grant_idx & s.ready;

    assign w_accept = s.avalid & s.ready;

    // Responses only count while a read is outstanding; strays are dropped
    assign w_rd_return = (state_q == ST_WAIT_R) & s.rvalid;
    assign m0.rvalid   = w_rd_return & ~owner_q;
    assign m1.rvalid   = w_rd_return &  owner_q;

    // Read data is broadcast; rvalid alone qualifies it
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;

    // Next-state computation for the arbitration FSM
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE, ST_ISSUE: begin
                if (w_accept) begin
                    owner_d = w_grant_idx;
                    last_d  = w_grant_idx;
                    state_d = (w_sel_wstrb == '0) ? ST_WAIT_R : ST_IDLE;
                end else if (w_grant_vld) begin
                    // Lock the grant so the presented request stays put
                    owner_d = w_grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_R: begin
                if (s.rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset wins, otherwise update only when enabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule
`default_nettype wire
